// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants and framebuffer geometry shared by the scanout and the game writer.
package vga_timing_pkg;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FP      = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_BP      = 10'd48;
    localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FP      = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BP      = 10'd33;
    localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HS_START  = H_VISIBLE + H_FP;
    localparam logic [9:0] HS_END    = HS_START + H_SYNC - 10'd1;
    localparam logic [9:0] VS_START  = V_VISIBLE + V_FP;
    localparam logic [9:0] VS_END    = VS_START + V_SYNC - 10'd1;

    localparam int unsigned FB_WIDTH    = 160;
    localparam int unsigned FB_HEIGHT   = 120;
    localparam int unsigned SCALE_SHIFT = 2;
    localparam int unsigned FB_ADDR_W   = 15;

    localparam int unsigned COLOR_R = 2;
    localparam int unsigned COLOR_G = 1;
    localparam int unsigned COLOR_B = 0;

    // Row stride of 160 done as 128 + 32 so no multiplier is needed.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [9:0] h, input logic [9:0] v);
        logic [FB_ADDR_W-1:0] row;
        logic [FB_ADDR_W-1:0] col;
        row = FB_ADDR_W'(v >> SCALE_SHIFT);
        col = FB_ADDR_W'(h >> SCALE_SHIFT);
        return (row << 7) + (row << 5) + col;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-clock divider, h/v raster counters, sync/visible decode and the frame tick.
module vga_sync_counter
    import vga_timing_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    output logic       clk_div,
    output logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       vis,
    output logic       hs_n,
    output logic       vs_n,
    output logic       frame_start
);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            clk_div <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            clk_div <= ~clk_div;
            if (pix_en) begin
                if (h_cnt == H_TOTAL - 10'd1) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? 10'd0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    always_comb begin
        pix_en      = clk_div;
        vis         = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
        hs_n        = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
        vs_n        = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
        // Gated with resetn so the tick can never leak out while held in reset.
        frame_start = resetn && pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer read side: 2-stage address/colour pipeline with 4x4 upscale onto the DE1 VGA pins.
module vga_fb_scanout
    import vga_timing_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    output logic [14:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic        frame_start,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B
);

    logic       clk_div;
    logic       pix_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       vis;
    logic       hs_n;
    logic       vs_n;
    logic       vis_s1;
    logic       hs_n_s1;
    logic       vs_n_s1;

    vga_sync_counter u_sync (
        .clock       (clock),
        .resetn      (resetn),
        .clk_div     (clk_div),
        .pix_en      (pix_en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .vis         (vis),
        .hs_n        (hs_n),
        .vs_n        (vs_n),
        .frame_start (frame_start)
    );

    // Stage 1 issues the RAM address; the RAM answers one clock later, which is
    // still before the next pix_en, so stage 2 samples rd_data directly.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rd_addr     <= '0;
            vis_s1      <= 1'b0;
            hs_n_s1     <= 1'b1;
            vs_n_s1     <= 1'b1;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (pix_en) begin
            rd_addr     <= vis ? fb_addr(h_cnt, v_cnt) : '0;
            vis_s1      <= vis;
            hs_n_s1     <= hs_n;
            vs_n_s1     <= vs_n;
            VGA_HS      <= hs_n_s1;
            VGA_VS      <= vs_n_s1;
            VGA_BLANK_N <= vis_s1;
            VGA_R       <= {10{vis_s1 & rd_data[COLOR_R]}};
            VGA_G       <= {10{vis_s1 & rd_data[COLOR_G]}};
            VGA_B       <= {10{vis_s1 & rd_data[COLOR_B]}};
        end
    end

    assign VGA_CLK    = clk_div;
    assign VGA_SYNC_N = 1'b1;

endmodule
